// File: rtl/instr_fetch_resp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instr_fetch_resp_pkg
// Brief  : Shared response type, NOP encoding and latency limits for the
//          instruction fetch/response block.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package instr_fetch_resp_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          LATENCY_MIN = 1;
  localparam int          LATENCY_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : resp_fifo
// Brief  : In-order response queue with single-cycle flush; head reads as
//          zero when empty.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module resp_fifo
  import instr_fetch_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output logic valid,
  output rsp_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  rsp_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign valid   = (cnt_q != '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && valid && !flush;
  assign head    = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instr_fetch_resp
// Brief  : Instruction memory with pipelined fetch, bounded outstanding
//          requests, in-order responses, flush and program-load port.
//          Define IFR_ERR_EN to flag misaligned/out-of-range fetches.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module instr_fetch_resp
  import instr_fetch_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                       (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [31:0]      mem_q [DEPTH];
  rsp_t             stg_q [LAT];
  rsp_t             stg_d [LAT];
  logic [LAT-1:0]   stg_vld_q, stg_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ld_idx;
  logic             acc;
  logic             pop;
  logic             fifo_push;
  rsp_t             rd_rsp;
  rsp_t             head;
  logic             unused_load_bits;

  assign rd_idx           = req_addr[IDX_W+1:2];
  assign ld_idx           = load_addr[IDX_W+1:2];
  assign unused_load_bits = ^{load_addr[31:IDX_W+2], load_addr[1:0]};

  // Gating with rst_n keeps the request port closed for the whole reset.
  assign req_ready = rst_n && ((cnt_q < MAX_CNT) || flush);
  assign acc       = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign fifo_push = stg_vld_q[LAT-1];

  always_comb begin
    rd_rsp.addr = req_addr;
    rd_rsp.data = mem_q[rd_idx];
    rd_rsp.err  = 1'b0;
`ifdef IFR_ERR_EN
    if ((req_addr[1:0] != 2'b00) ||
        ({1'b0, req_addr} >= (33'(DEPTH) << 2))) begin
      rd_rsp.data = NOP_INSTR;
      rd_rsp.err  = 1'b1;
    end
`endif
  end

  // A request accepted alongside flush lands in stage 0 and survives.
  always_comb begin
    stg_d        = stg_q;
    stg_vld_d    = stg_vld_q;
    stg_d[0]     = rd_rsp;
    stg_vld_d[0] = acc;
    for (int k = 1; k < LAT; k++) begin
      stg_d[k]     = stg_q[k-1];
      stg_vld_d[k] = stg_vld_q[k-1] && !flush;
    end
    if (flush) cnt_d = CNT_W'(acc);
    else       cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      stg_vld_q <= '0;
      for (int k = 0; k < LAT; k++) stg_q[k] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
    end
  end

  // Program memory survives reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[ld_idx] <= load_data;
  end

  resp_fifo #(
    .DEPTH (MAX_OUT)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (stg_q[LAT-1]),
    .pop       (pop),
    .valid     (rsp_valid),
    .head      (head)
  );

  assign rsp_data = head.data;
  assign rsp_addr = head.addr;
  assign rsp_err  = head.err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_instr_fetch_resp
// Brief  : Directed self-checking bench for instr_fetch_resp (default
//          parameters; honours IFR_ERR_EN when defined).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_instr_fetch_resp;

  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h0010_0113;
  localparam logic [31:0] W2  = 32'h2222_2222;
  localparam logic [31:0] W3  = 32'h3333_3333;
  localparam logic [31:0] W16 = 32'h4040_4040;
  localparam logic [31:0] W2N = 32'hBEEF_0002;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_resp #(
    .DEPTH   (1024),
    .LATENCY (2),
    .MAX_OUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Single request, optionally with a same-cycle load to the same word.
  // lat = edges between acceptance and the first visible response, -1 on timeout.
  task automatic do_req(input logic [31:0] a, input bit with_load, input logic [31:0] ld,
                        output logic [31:0] d, output logic [31:0] ra,
                        output logic e, output int lat);
    bit found;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    if (with_load) begin load_en = 1'b1; load_addr = a; load_data = ld; end
    @(negedge clk);
    req_valid = 1'b0; load_en = 1'b0;
    d = '0; ra = '0; e = 1'b0; lat = -1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rsp_valid) begin
        d = rsp_data; ra = rsp_addr; e = rsp_err; lat = i; found = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL rst_rsp_addr: got %h expected 0", rsp_addr); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", dut.cnt_q); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_early0: got %b expected 0", rsp_valid); end
    req_addr = 32'h4;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_early1: got %b expected 0", rsp_valid); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== W0 || rsp_addr !== 32'h0)
      begin errors++; $display("FAIL b2b_rsp0: got v=%b d=%h a=%h expected v=1 d=%h a=0", rsp_valid, rsp_data, rsp_addr, W0); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== W1 || rsp_addr !== 32'h4)
      begin errors++; $display("FAIL b2b_rsp1: got v=%b d=%h a=%h expected v=1 d=%h a=4", rsp_valid, rsp_data, rsp_addr, W1); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    int got;
    exp_a = '{32'h4, 32'h8, 32'hC, 32'h0};
    exp_d = '{W1, W2, W3, W0};
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 1", i, req_ready); end
      @(negedge clk);
    end
    req_addr = 32'h0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", req_ready); end
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== W0 || rsp_addr !== 32'h0)
      begin errors++; $display("FAIL bp_head: got v=%b d=%h a=%h expected v=1 d=%h a=0", rsp_valid, rsp_data, rsp_addr, W0); end
    @(negedge clk);
    checks++; if (rsp_data !== W0 || rsp_addr !== 32'h0 || req_ready !== 1'b0)
      begin errors++; $display("FAIL bp_hold: got d=%h a=%h rdy=%b expected d=%h a=0 rdy=0", rsp_data, rsp_addr, req_ready, W0); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got %b expected 1", req_ready); end
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_refull: got %b expected 0", req_ready); end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (rsp_valid) begin
        checks++;
        if (rsp_addr !== exp_a[got] || rsp_data !== exp_d[got]) begin
          errors++;
          $display("FAIL bp_order_%0d: got d=%h a=%h expected d=%h a=%h", got, rsp_data, rsp_addr, exp_d[got], exp_a[got]);
        end
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got != 4) begin errors++; $display("FAIL bp_count: got %0d responses expected 4", got); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_empty_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_flush;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
    @(negedge clk);
    req_addr = 32'hC;
    @(negedge clk);
    req_addr = 32'h40; flush = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (dut.cnt_q !== 3'd1) begin errors++; $display("FAIL fl_count: got %0d expected 1", dut.cnt_q); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_after: got %b expected 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_gap: got %b expected 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h40 || rsp_data !== W16)
      begin errors++; $display("FAIL fl_survivor: got v=%b d=%h a=%h expected v=1 d=%h a=40", rsp_valid, rsp_data, rsp_addr, W16); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_extra_%0d: got %b expected 0", c, rsp_valid); end
    end
  endtask

  task automatic test_err;
    logic [31:0] d, ra;
    logic e;
    int lat;
    do_req(32'h6, 1'b0, 32'h0, d, ra, e, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL err_lat: got %0d expected 2", lat); end
    checks++; if (ra !== 32'h6) begin errors++; $display("FAIL err_addr6: got %h expected 6", ra); end
`ifdef IFR_ERR_EN
    checks++; if (e !== 1'b1 || d !== 32'h0000_0013) begin errors++; $display("FAIL err_mis: got e=%b d=%h expected e=1 d=00000013", e, d); end
`else
    checks++; if (e !== 1'b0 || d !== W1) begin errors++; $display("FAIL err_mis: got e=%b d=%h expected e=0 d=%h", e, d, W1); end
`endif
    do_req(32'h1004, 1'b0, 32'h0, d, ra, e, lat);
`ifdef IFR_ERR_EN
    checks++; if (e !== 1'b1 || d !== 32'h0000_0013) begin errors++; $display("FAIL err_range: got e=%b d=%h expected e=1 d=00000013", e, d); end
`else
    checks++; if (e !== 1'b0 || d !== W1) begin errors++; $display("FAIL err_wrap: got e=%b d=%h expected e=0 d=%h", e, d, W1); end
`endif
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d, ra;
    logic e;
    int lat;
    bit seen;
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      @(negedge clk);
    end
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0)
      begin errors++; $display("FAIL mr_in_reset: got v=%b rdy=%b expected 0 0", rsp_valid, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b expected 1", req_ready); end
    rsp_ready = 1'b1; seen = 1'b0;
    repeat (8) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL mr_ghost: got a response expected none"); end
    do_req(32'h0, 1'b0, 32'h0, d, ra, e, lat);
    checks++; if (d !== W0) begin errors++; $display("FAIL mr_mem0: got %h expected %h", d, W0); end
    do_req(32'h4, 1'b0, 32'h0, d, ra, e, lat);
    checks++; if (d !== W1) begin errors++; $display("FAIL mr_mem1: got %h expected %h", d, W1); end
  endtask

  task automatic test_load_collision;
    logic [31:0] d, ra;
    logic e;
    int lat;
    do_req(32'h8, 1'b1, W2N, d, ra, e, lat);
    checks++; if (d !== W2 || lat < 0) begin errors++; $display("FAIL lc_old: got %h lat=%0d expected %h", d, lat, W2); end
    do_req(32'h8, 1'b0, 32'h0, d, ra, e, lat);
    checks++; if (d !== W2N) begin errors++; $display("FAIL lc_new: got %h expected %h", d, W2N); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    load_word(32'h0,  W0);
    load_word(32'h4,  W1);
    load_word(32'h8,  W2);
    load_word(32'hC,  W3);
    load_word(32'h40, W16);
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_err;
    test_reset_midflight;
    test_load_collision;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_resp.md
INSTR_FETCH_RESP -- requirements
Module: instr_fetch_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving instruction memory size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the request-to-response pipeline depth in cycles (legal range 1..4).
REQ-003 The block SHALL have parameter MAX_OUT, default 4, giving the maximum number of outstanding requests.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
- CLK  input  1  clock
- RST_N  input  1  asynchronous active-low reset
- REQ_VALID  input  1  fetch request present
- REQ_ADDR  input  32  byte address, driven from the program counter
- REQ_READY  output  1  request accepted this cycle when high with REQ_VALID
- RSP_VALID  output  1  response present
- RSP_READY  input  1  consumer takes response
- RSP_DATA  output  32  instruction word
- RSP_ADDR  output  32  address of the returned instruction
- RSP_ERR  output  1  fetch fault
- FLUSH  input  1  discard all in-flight and buffered responses (branch/jump redirect)
- LOAD_EN  input  1  program-load write strobe
- LOAD_ADDR  input  32  program-load byte address
- LOAD_DATA  input  32  program-load word

Function
REQ-005 A request SHALL be accepted on a rising CLK edge when REQ_VALID and REQ_READY are both high.
REQ-006 REQ_READY SHALL be high when the outstanding count is below MAX_OUT, or when FLUSH is high.
REQ-007 The outstanding count SHALL increment per acceptance, decrement per RSP_VALID&&RSP_READY, and remain unchanged when both occur in the same cycle.
REQ-008 An accepted request SHALL read memory word REQ_ADDR[log2(DEPTH)+1:2] and traverse LATENCY pipeline stages before entering the response FIFO.
REQ-009 The earliest RSP_VALID for a request SHALL occur LATENCY cycles after its acceptance edge.
REQ-010 The response FIFO SHALL be MAX_OUT entries deep, SHALL return responses in acceptance order, and SHALL never overflow, as guaranteed by REQ-006.
REQ-011 RSP_DATA, RSP_ADDR and RSP_ERR SHALL be held stable while RSP_VALID is high and RSP_READY is low.
REQ-012 When FLUSH is high, the block SHALL invalidate all pipeline stages and FIFO entries and SHALL zero the outstanding count at the next edge.
REQ-013 A request accepted in the same cycle as FLUSH SHALL survive the flush and yield the next response, with the outstanding count becoming 1.
REQ-014 RSP_VALID SHALL be low in the cycle following a FLUSH unless LATENCY rules already deliver a surviving request.
REQ-015 LOAD_EN SHALL write LOAD_DATA to the word at LOAD_ADDR at the clock edge.
REQ-016 A read of the same word in the same cycle as a LOAD_EN write SHALL return the old contents.
REQ-017 A word-aligned address at or beyond DEPTH*4 SHALL wrap modulo DEPTH when IFR_ERR_EN is undefined.

Reset
REQ-018 While RST_N is low, the block SHALL assert RSP_VALID=0, RSP_DATA=0, RSP_ADDR=0, RSP_ERR=0, REQ_READY=0, outstanding count 0, and all stages invalid.
REQ-019 Assertion of RST_N mid-operation SHALL discard all in-flight requests without producing a response.
REQ-020 Memory contents SHALL be unaffected by reset.
REQ-021 REQ_READY SHALL rise in the first cycle after RST_N deasserts.

Configuration
REQ-022 When macro IFR_ERR_EN is defined, a request with REQ_ADDR[1:0]!=0 or REQ_ADDR>=DEPTH*4 SHALL return RSP_ERR=1 and RSP_DATA=32'h00000013 (NOP) with normal latency and ordering.
REQ-023 When IFR_ERR_EN is undefined, RSP_ERR SHALL be tied to 0, REQ_ADDR[1:0] SHALL be ignored, and out-of-range addresses SHALL wrap per REQ-017.

Structure
REQ-024 The shared package SHALL hold the response struct (data, addr, err), the NOP constant 32'h00000013, and the LATENCY range limits.
REQ-025 The response FIFO SHALL be a separate sub-module named resp_fifo, parameterised by depth and using the response struct.

Verification
REQ-026 Load word 0 with 32'h00500093 and word 1 with 32'h00100113, request 0x0 then 0x4 back-to-back with RSP_READY=1, and LATENCY=2: responses SHALL appear at cycles 2 and 3 with those data and RSP_ADDR values.
REQ-027 Hold RSP_READY=0 and issue 5 requests: REQ_READY SHALL drop after the 4th acceptance and rise again the cycle after one response is taken.
REQ-028 Issue requests to 0x8 and 0xC, assert FLUSH together with a request to 0x40: the only response returned SHALL be for 0x40, and the outstanding count SHALL be 1.
REQ-029 With IFR_ERR_EN defined, request 0x6: the bench SHALL observe RSP_ERR=1 and RSP_DATA=32'h00000013; without IFR_ERR_EN, request 0x6 SHALL return word 1.
REQ-030 Assert RST_N low while 3 requests are in flight: the bench SHALL observe no response after release, REQ_READY=1 one cycle after release, and memory contents intact.
REQ-031 Simultaneously write word 2 via LOAD_EN and request 0x8: the response SHALL carry the old word, and a re-request SHALL return the new word.
